// File: rtl/score_display_driver.sv
`timescale 1ns/1ps
// score_display_driver
// Holds a 4-digit BCD game score and time-multiplexes its digits onto the
// digit-select / nibble / dot inputs of a four-digit seven-segment decoder.
// A point flashes the decimal point on digit 0 for a number of scan rounds.
//
// Ports:
//   CLK             system clock
//   RESET           asynchronous, active-high reset
//   INC_IN          add one point per high cycle (saturates at 9999)
//   CLEAR_IN        synchronous score clear, wins over INC_IN
//   SEG_SELECT_OUT  digit index to the decoder, 0 = units (rightmost)
//   BIN_OUT         BCD nibble of the selected digit
//   DOT_OUT         decimal point, active low (0 = lit)
//   SCORE_OUT       packed BCD score {thousands, hundreds, tens, units}
//   SAT_OUT         high while the score equals 9999
module score_display_driver #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned FLASH_SCANS = 50
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        INC_IN,
  input  logic        CLEAR_IN,
  output logic [1:0]  SEG_SELECT_OUT,
  output logic [3:0]  BIN_OUT,
  output logic        DOT_OUT,
  output logic [15:0] SCORE_OUT,
  output logic        SAT_OUT
);

  localparam int unsigned REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned FL_W  = (FLASH_SCANS > 0) ? $clog2(FLASH_SCANS + 1) : 1;
  localparam logic [15:0] SCORE_MAX = 16'h9999;

  logic [REF_W-1:0] r_refresh;
  logic [1:0]       r_digit;
  logic [15:0]      r_score;
  logic [FL_W-1:0]  r_flash;

  logic             w_slot_wrap;
  logic             w_scan_wrap;
  logic             w_sat;
  logic             w_flash_nz;
  logic             w_c1;
  logic             w_c2;
  logic             w_c3;
  logic [15:0]      w_score_inc;
  logic [15:0]      w_score_next;
  logic [FL_W-1:0]  w_flash_next;
  logic [3:0]       w_nibble;

  // Slot / scan-round boundaries
  assign w_slot_wrap = (r_refresh == REF_W'(REFRESH_DIV - 1));
  assign w_scan_wrap = w_slot_wrap && (r_digit == 2'd3);
  assign w_sat       = (r_score == SCORE_MAX);
  assign w_flash_nz  = (r_flash != '0);

  // Decimal ripple carries: a digit steps only when every lower digit is 9
  assign w_c1 = (r_score[3:0] == 4'd9);
  assign w_c2 = w_c1 && (r_score[7:4] == 4'd9);
  assign w_c3 = w_c2 && (r_score[11:8] == 4'd9);

  // BCD increment, one nibble at a time
  always_comb begin
    w_score_inc = r_score;
    w_score_inc[3:0] = w_c1 ? 4'd0 : r_score[3:0] + 4'd1;
    if (w_c1) begin
      w_score_inc[7:4] = (r_score[7:4] == 4'd9) ? 4'd0 : r_score[7:4] + 4'd1;
    end
    if (w_c2) begin
      w_score_inc[11:8] = (r_score[11:8] == 4'd9) ? 4'd0 : r_score[11:8] + 4'd1;
    end
    if (w_c3) begin
      w_score_inc[15:12] = (r_score[15:12] == 4'd9) ? 4'd0 : r_score[15:12] + 4'd1;
    end
  end

  // Score and flash next state: clear, then increment/reload, then decay
  always_comb begin
    w_score_next = r_score;
    w_flash_next = r_flash;
    if (CLEAR_IN) begin
      w_score_next = 16'h0000;
      w_flash_next = '0;
    end else if (INC_IN && !w_sat) begin
      w_score_next = w_score_inc;
      w_flash_next = FL_W'(FLASH_SCANS);
    end else if (w_scan_wrap && w_flash_nz) begin
      // Saturated INC_IN lands here too, so the flash keeps decaying
      w_flash_next = r_flash - FL_W'(1);
    end
  end

  // Nibble of the digit currently being scanned
  always_comb begin
    w_nibble = r_score[3:0];
    case (r_digit)
      2'd0: w_nibble = r_score[3:0];
      2'd1: w_nibble = r_score[7:4];
      2'd2: w_nibble = r_score[11:8];
      2'd3: w_nibble = r_score[15:12];
      default: w_nibble = r_score[3:0];
    endcase
  end

  // Refresh counter and digit index
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_refresh <= '0;
      r_digit   <= 2'd0;
    end else begin
      r_refresh <= w_slot_wrap ? '0 : r_refresh + REF_W'(1);
      if (w_slot_wrap) begin
        r_digit <= r_digit + 2'd1;
      end
    end
  end

  // Score and flash registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_score <= 16'h0000;
      r_flash <= '0;
    end else begin
      r_score <= w_score_next;
      r_flash <= w_flash_next;
    end
  end

  // Display outputs: one cycle behind the digit/score/flash registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      SEG_SELECT_OUT <= 2'd0;
      BIN_OUT        <= 4'd0;
      DOT_OUT        <= 1'b1;
    end else begin
      SEG_SELECT_OUT <= r_digit;
      BIN_OUT        <= w_nibble;
      DOT_OUT        <= ~(w_flash_nz && (r_digit == 2'd0));
    end
  end

  // Saturation flag tracks the score register edge-for-edge
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      SAT_OUT <= 1'b0;
    end else begin
      SAT_OUT <= (w_score_next == SCORE_MAX);
    end
  end

  assign SCORE_OUT = r_score;

endmodule

// File: tb/tb_score_display_driver.sv
`timescale 1ns/1ps
module tb_score_display_driver;

  localparam int unsigned RD = 4;
  localparam int unsigned FS = 2;

  logic        CLK;
  logic        RESET;
  logic        INC_IN;
  logic        CLEAR_IN;
  logic [1:0]  SEG_SELECT_OUT;
  logic [3:0]  BIN_OUT;
  logic        DOT_OUT;
  logic [15:0] SCORE_OUT;
  logic        SAT_OUT;

  score_display_driver #(
    .REFRESH_DIV(RD),
    .FLASH_SCANS(FS)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .INC_IN(INC_IN),
    .CLEAR_IN(CLEAR_IN),
    .SEG_SELECT_OUT(SEG_SELECT_OUT),
    .BIN_OUT(BIN_OUT),
    .DOT_OUT(DOT_OUT),
    .SCORE_OUT(SCORE_OUT),
    .SAT_OUT(SAT_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [1:0]  seg;
    logic [3:0]  bin;
    logic        dot;
    logic [15:0] score;
    logic        sat;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;

  // Reference model state
  int          m_ref;
  int          m_dig;
  int          m_flash;
  logic [15:0] m_score;

  function automatic logic [15:0] bcd_add1(input logic [15:0] s);
    int v;
    v = int'(s[15:12]) * 1000 + int'(s[11:8]) * 100 + int'(s[7:4]) * 10 + int'(s[3:0]) + 1;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_ref   = 0;
    m_dig   = 0;
    m_flash = 0;
    m_score = 16'h0000;
    sb_q.delete();
  endtask

  // One clock: drive, predict, wait for the edge, compare popped prediction
  task automatic cyc(input logic inc, input logic clr);
    exp_t   e;
    exp_t   got;
    logic   wrap;
    INC_IN   = inc;
    CLEAR_IN = clr;
    e.seg = 2'(m_dig);
    e.bin = m_score[4*m_dig +: 4];
    e.dot = !((m_flash != 0) && (m_dig == 0));
    wrap  = (m_ref == int'(RD) - 1);
    if (clr) begin
      m_score = 16'h0000;
      m_flash = 0;
    end else if (inc && (m_score != 16'h9999)) begin
      m_score = bcd_add1(m_score);
      m_flash = int'(FS);
    end else if (wrap && (m_dig == 3) && (m_flash != 0)) begin
      m_flash = m_flash - 1;
    end
    m_ref = wrap ? 0 : m_ref + 1;
    if (wrap) m_dig = (m_dig + 1) % 4;
    e.score = m_score;
    e.sat   = (m_score == 16'h9999);
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
    got = {SEG_SELECT_OUT, BIN_OUT, DOT_OUT, SCORE_OUT, SAT_OUT};
    e = sb_q.pop_front();
    chk("cycle_outputs", 32'(got), 32'(e));
  endtask

  // Hard stop in case something wedges
  initial begin
    #1000000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lit;
    int bad;
    int guard;
    logic [3:0] seen [4];
    logic [3:0] exp_nib [4];
    exp_nib = '{4'd0, 4'd0, 4'd1, 4'd1};
    seen    = '{4'hF, 4'hF, 4'hF, 4'hF};

    RESET    = 1'b1;
    INC_IN   = 1'b0;
    CLEAR_IN = 1'b0;
    model_reset();
    @(posedge CLK);
    #1;
    chk("rst_seg",   32'(SEG_SELECT_OUT), 32'd0);
    chk("rst_bin",   32'(BIN_OUT),        32'd0);
    chk("rst_dot",   32'(DOT_OUT),        32'd1);
    chk("rst_score", 32'(SCORE_OUT),      32'h0);
    chk("rst_sat",   32'(SAT_OUT),        32'd0);
    RESET = 1'b0;

    // Scan: 0,1,2,3,0 with RD cycles each
    for (int k = 1; k <= 20; k++) begin
      cyc(1'b0, 1'b0);
      chk("scan_seg", 32'(SEG_SELECT_OUT), 32'(((k - 1) / 4) % 4));
      chk("scan_bin", 32'(BIN_OUT), 32'd0);
      chk("scan_dot", 32'(DOT_OUT), 32'd1);
    end

    // BCD carry
    for (int i = 0; i < 1099; i++) begin
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
    end
    chk("score_1099", 32'(SCORE_OUT), 32'h1099);
    cyc(1'b1, 1'b0);
    chk("score_1100", 32'(SCORE_OUT), 32'h1100);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b0);
      seen[SEG_SELECT_OUT] = BIN_OUT;
    end
    for (int d = 0; d < 4; d++) chk("digit_1100", 32'(seen[d]), 32'(exp_nib[d]));

    // Saturation
    guard = 0;
    while ((m_score != 16'h9999) && (guard < 9000)) begin
      cyc(1'b1, 1'b0);
      guard++;
    end
    chk("score_9999", 32'(SCORE_OUT), 32'h9999);
    chk("sat_9999",   32'(SAT_OUT),   32'd1);
    for (int i = 0; i < 48; i++) cyc(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0);
      chk("sat_hold_score", 32'(SCORE_OUT), 32'h9999);
      chk("sat_hold_sat",   32'(SAT_OUT),   32'd1);
      chk("sat_hold_dot",   32'(DOT_OUT),   32'd1);
    end
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b0);
      chk("sat_no_flash", 32'(DOT_OUT), 32'd1);
    end

    // Clear priority
    cyc(1'b0, 1'b1);
    chk("clear_score", 32'(SCORE_OUT), 32'h0);
    chk("clear_sat",   32'(SAT_OUT),   32'd0);
    for (int i = 0; i < 42; i++) cyc(1'b1, 1'b0);
    chk("score_0042", 32'(SCORE_OUT), 32'h0042);
    cyc(1'b1, 1'b1);
    chk("clr_inc_score", 32'(SCORE_OUT), 32'h0);
    chk("clr_inc_sat",   32'(SAT_OUT),   32'd0);
    cyc(1'b0, 1'b0);
    chk("clr_inc_dot",   32'(DOT_OUT),   32'd1);

    // Flash: pulse on the scan-wrap edge, expect two lit digit-0 slots
    guard = 0;
    while (!((m_ref == int'(RD) - 1) && (m_dig == 3)) && (guard < 16)) begin
      cyc(1'b0, 1'b0);
      guard++;
    end
    cyc(1'b1, 1'b0);
    lit = 0;
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      cyc(1'b0, 1'b0);
      if (DOT_OUT == 1'b0) begin
        lit++;
        if (SEG_SELECT_OUT != 2'd0) bad++;
      end
    end
    chk("flash_lit",     32'(lit), 32'd8);
    chk("flash_off_dig", 32'(bad), 32'd0);
    lit = 0;
    for (int i = 0; i < 32; i++) begin
      cyc(1'b0, 1'b0);
      if (DOT_OUT == 1'b0) lit++;
    end
    chk("flash_done", 32'(lit), 32'd0);

    // Asynchronous reset mid-operation
    cyc(1'b0, 1'b1);
    for (int i = 0; i < 357; i++) cyc(1'b1, 1'b0);
    chk("score_0357", 32'(SCORE_OUT), 32'h0357);
    guard = 0;
    while ((m_dig != 2) && (guard < 16)) begin
      cyc(1'b0, 1'b0);
      guard++;
    end
    INC_IN = 1'b0;
    CLEAR_IN = 1'b0;
    #2;
    RESET = 1'b1;
    #1;
    chk("arst_seg",   32'(SEG_SELECT_OUT), 32'd0);
    chk("arst_bin",   32'(BIN_OUT),        32'd0);
    chk("arst_dot",   32'(DOT_OUT),        32'd1);
    chk("arst_score", 32'(SCORE_OUT),      32'h0);
    chk("arst_sat",   32'(SAT_OUT),        32'd0);
    model_reset();
    @(posedge CLK);
    #1;
    chk("arst_hold_score", 32'(SCORE_OUT), 32'h0);
    #2;
    RESET = 1'b0;
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    chk("post_rst_score", 32'(SCORE_OUT), 32'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/score_display_driver.md
Name: score_display_driver

Overview:
- Upstream stage for the four-digit seven-segment decoder.
- Holds the game score as a 4-digit BCD counter and time-multiplexes its digits onto the decoder's digit-select, nibble and dot inputs.
- Also produces a brief decimal-point flash on digit 0 each time a point is scored.
- Sits between the game-logic point pulse and the segment decoder.

Parameters:
- REFRESH_DIV, 100000: clock cycles per digit slot; at least 2.
- FLASH_SCANS, 50: number of full 4-digit scan rounds the dot stays lit after a point; at least 1.

Ports:
- CLK  input  1  system clock.
- RESET  input  1  asynchronous, active-high reset.
- INC_IN  input  1  add one point; sampled every cycle; each high cycle counts one.
- CLEAR_IN  input  1  synchronous score clear.
- SEG_SELECT_OUT  output  2  digit index to the decoder; 0 is the rightmost (units) digit.
- BIN_OUT  output  4  BCD nibble of the selected digit.
- DOT_OUT  output  1  decimal point; 0 = lit, 1 = off.
- SCORE_OUT  output  16  packed BCD score {thousands, hundreds, tens, units}.
- SAT_OUT  output  1  high while the score equals 9999.

Behaviour:
- Reset (asynchronous, takes effect immediately, in any state):
  - refresh counter = 0, digit index = 0, score = 0x0000, flash counter = 0.
  - SEG_SELECT_OUT = 0, BIN_OUT = 0, DOT_OUT = 1, SCORE_OUT = 0, SAT_OUT = 0.
  - Reset asserted mid-scan or mid-flash abandons all state. Counting resumes from slot 0 on the first edge after release.
- Refresh counter:
  - Counts 0 to REFRESH_DIV-1, then wraps to 0.
  - On the wrap edge the digit index advances 0→1→2→3→0.
  - Each digit slot is exactly REFRESH_DIV cycles; a full scan round is 4*REFRESH_DIV cycles.
- Display outputs:
  - All outputs are registered.
  - SEG_SELECT_OUT, BIN_OUT and DOT_OUT are loaded every cycle from the current digit-index, score and flash registers, so they lag those registers by one cycle.
  - BIN_OUT is the score nibble at index SEG_SELECT (0 = units, 3 = thousands).
  - A score change becomes visible on SCORE_OUT one cycle after the INC_IN edge, and on BIN_OUT one cycle after that if that digit is selected.
- Score arithmetic:
  - Decimal ripple increment: a digit at 9 becomes 0 and carries into the next digit.
  - Nibbles never hold A–F.
  - At 9999, INC_IN is ignored: the score saturates, never wraps to 0000. SAT_OUT = 1 while the score is 9999.
- Priority, per cycle:
  - CLEAR_IN high: score becomes 0000 and the flash counter becomes 0, regardless of INC_IN.
  - Otherwise INC_IN high and score below 9999: increment the score and load the flash counter with FLASH_SCANS.
  - Otherwise INC_IN high and score = 9999: no change; the flash counter is not reloaded.
- Flash counter:
  - Decrements by 1 on each digit-index wrap 3→0 while it is nonzero.
  - A reload on the same edge as a wrap wins over the decrement.
  - DOT_OUT = 0 when the flash counter is nonzero and the digit index is 0; otherwise DOT_OUT = 1.
- Refresh counter and digit index are unaffected by CLEAR_IN and INC_IN.
- Combinational output path: none; there is no path from INC_IN or CLEAR_IN to any output within the same cycle.

Test Plan:
- Reset/scan, REFRESH_DIV=4:
  - Release RESET and hold inputs low.
  - Required: SEG_SELECT_OUT steps 0,1,2,3,0 with 4 cycles per value; BIN_OUT = 0 and DOT_OUT = 1 throughout.
- BCD carry:
  - Apply 1099 single-cycle INC_IN pulses.
  - Required: SCORE_OUT = 0x1099. One more pulse gives 0x1100. When each digit is selected, BIN_OUT shows 0,0,1,1 for indices 0..3.
- Saturation:
  - Count to 0x9999, then hold INC_IN high for 10 cycles.
  - Required: SCORE_OUT stays 0x9999, SAT_OUT = 1, and the flash counter is not reloaded.
- Clear priority:
  - At score 0x0042, assert CLEAR_IN and INC_IN in the same cycle.
  - Required: SCORE_OUT = 0x0000 next cycle, DOT_OUT = 1, SAT_OUT = 0.
- Flash, FLASH_SCANS=2, REFRESH_DIV=4:
  - Pulse INC_IN once.
  - Required: DOT_OUT = 0 during the digit-0 slots for the next 2 full scan rounds, then DOT_OUT stays 1.
- Asynchronous reset mid-operation:
  - At score 0x0357 with the digit index at 2, assert RESET between clock edges.
  - Required: all outputs go to their reset values before the next edge.
